gb_bus_target: RTL and testbench

//  Slave-side responder for the CPU wrapper's registered bus strobes (mreq_n/iorq_n/rd_n/wr_n, m1_n).

---
 rtl/gb_bus_pkg.sv | 22 ++
 rtl/gb_addr_decode.sv | 40 ++++
 rtl/gb_bus_target.sv | 157 +++++++++++++++
 tb/tb_gb_bus_target.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_bus_pkg.sv
// rtl/gb_bus_pkg.sv - shared types and constants for the bus target
// Purpose: FSM state and address-region enums plus the default open-bus value.
// Ports: none (package).
package gb_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } tgt_state_t;

    typedef enum logic [2:0] {
        RGN_ROM,
        RGN_RAM,
        RGN_IO,
        RGN_UNMAP,
        RGN_INTA
    } rgn_t;

    localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

endpackage

// File: rtl/gb_addr_decode.sv
// rtl/gb_addr_decode.sv - combinational access region decoder
// Purpose: classify the current strobes/address into a region.
// Ports:
//   a       in  16  CPU address
//   mreq_n  in  1   memory request strobe
//   iorq_n  in  1   IO request strobe
//   m1_n    in  1   opcode-fetch / int-ack qualifier
//   rgn     out     decoded region (rgn_t)
import gb_bus_pkg::*;

module gb_addr_decode #(
    parameter logic [15:0] ROM_LAST = 16'h7FFF,
    parameter logic [15:0] UNMAP_LO = 16'hFEA0,
    parameter logic [15:0] UNMAP_HI = 16'hFEFF
) (
    input  logic [15:0] a,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        m1_n,
    output rgn_t        rgn
);

    always_comb begin
        rgn = RGN_UNMAP;
        if (!iorq_n && !m1_n) begin
            rgn = RGN_INTA;
        end else if (!iorq_n) begin
            rgn = RGN_IO;
        end else if (!mreq_n) begin
            if (a <= ROM_LAST) begin
                rgn = RGN_ROM;
            end else if ((a >= UNMAP_LO) && (a <= UNMAP_HI)) begin
                rgn = RGN_UNMAP;
            end else begin
                rgn = RGN_RAM;
            end
        end
    end

endmodule

// File: rtl/gb_bus_target.sv
// rtl/gb_bus_target.sv - CPU bus slave with req/ack backend handshake and timeout
// Purpose: decode CPU strobes, stall via wait_n, run a req/ack handshake to the
//          memory backend, return read data / int vector / open-bus value.
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   a, cpu_do                CPU address and write data
//   m1_n, mreq_n, iorq_n,
//   rd_n, wr_n               CPU strobes (active low)
//   wait_n                   0 stalls the CPU (combinational)
//   cpu_di                   registered read data to CPU
//   int_vec                  vector returned on interrupt acknowledge
//   mem_req, mem_we,
//   mem_addr, mem_wdata      backend request side
//   mem_rdata, mem_ack       backend response side
//   bus_err                  1-cycle pulse on backend timeout
import gb_bus_pkg::*;

module gb_bus_target #(
    parameter logic [15:0] ROM_LAST = 16'h7FFF,
    parameter logic [15:0] UNMAP_LO = 16'hFEA0,
    parameter logic [15:0] UNMAP_HI = 16'hFEFF,
    parameter int          TIMEOUT  = 16,
    parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [7:0]  cpu_do,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic        wait_n,
    output logic [7:0]  cpu_di,
    input  logic [7:0]  int_vec,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    localparam int              TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   T_MAX  = TW'(TIMEOUT);

    tgt_state_t     state, state_nxt;
    rgn_t           rgn;
    logic           act;
    logic [TW-1:0]  timer, timer_nxt;
    logic [7:0]     cpu_di_nxt;
    logic           mem_req_nxt, mem_we_nxt, bus_err_nxt;
    logic [15:0]    mem_addr_nxt;
    logic [7:0]     mem_wdata_nxt;

    gb_addr_decode #(
        .ROM_LAST (ROM_LAST),
        .UNMAP_LO (UNMAP_LO),
        .UNMAP_HI (UNMAP_HI)
    ) u_decode (
        .a      (a),
        .mreq_n (mreq_n),
        .iorq_n (iorq_n),
        .m1_n   (m1_n),
        .rgn    (rgn)
    );

    // Int-ack carries no rd/wr strobe, so it counts as an access on its own.
    assign act    = ((~mreq_n | ~iorq_n) & (~rd_n | ~wr_n)) | (~iorq_n & ~m1_n);
    assign wait_n = ~(act & (state != DONE));

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        cpu_di_nxt    = cpu_di;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        bus_err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (act) begin
                    mem_addr_nxt  = a;
                    mem_wdata_nxt = cpu_do;
                    mem_we_nxt    = ~wr_n;
                    timer_nxt     = '0;
                    if (rgn == RGN_INTA) begin
                        cpu_di_nxt = int_vec;
                        state_nxt  = DONE;
                    end else if (!wr_n && ((rgn == RGN_ROM) || (rgn == RGN_UNMAP))) begin
                        state_nxt  = DONE;
                    end else if (rgn == RGN_UNMAP) begin
                        cpu_di_nxt = OPEN_BUS;
                        state_nxt  = DONE;
                    end else begin
                        mem_req_nxt = 1'b1;
                        state_nxt   = REQ;
                    end
                end
            end
            REQ: begin
                if (timer != T_MAX) begin
                    timer_nxt = timer + 1'b1;
                end
                // Ack beats a coincident timeout. If the CPU already let go of
                // the strobes there is nobody to wait for, so go straight home.
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    if (!mem_we) begin
                        cpu_di_nxt = mem_rdata;
                    end
                    state_nxt = act ? DONE : IDLE;
                end else if (timer == T_LAST) begin
                    mem_req_nxt = 1'b0;
                    cpu_di_nxt  = OPEN_BUS;
                    bus_err_nxt = 1'b1;
                    state_nxt   = act ? DONE : IDLE;
                end
            end
            DONE: begin
                if (!act) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            cpu_di    <= 8'hFF;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            cpu_di    <= cpu_di_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            bus_err   <= bus_err_nxt;
        end
    end

endmodule

// File: tb/tb_gb_bus_target.sv
// tb/tb_gb_bus_target.sv - self-checking bench for gb_bus_target
module tb_gb_bus_target;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic [7:0]  cpu_do;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n;
    logic        wait_n;
    logic [7:0]  cpu_di;
    logic [7:0]  int_vec;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] model_di;

    gb_bus_target dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .cpu_do    (cpu_do),
        .m1_n      (m1_n),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .wait_n    (wait_n),
        .cpu_di    (cpu_di),
        .int_vec   (int_vec),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_strobes();
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
    endtask

    // kind: 0=memory 1=IO 2=int-ack; dir: 0=read 1=write 2=both strobes low
    // ack_at: REQ cycle (1-based) in which the backend acks; 0 = never
    task automatic access(input int kind, input int dir, input logic [15:0] addr,
                          input logic [7:0] wd, input int ack_at,
                          input logic [7:0] rd_val, input logic [7:0] vec);
        logic       is_wr, rom, unm, tmo;
        int         exp_rq, waits, rq;
        logic [7:0] exp_di;
        is_wr  = (kind != 2) && (dir != 0);
        rom    = addr <= 16'h7FFF;
        unm    = (addr >= 16'hFEA0) && (addr <= 16'hFEFF);
        tmo    = 1'b0;
        exp_rq = 0;
        exp_di = model_di;
        if (kind == 2) begin
            exp_di = vec;
        end else if (kind == 0 && is_wr && (rom || unm)) begin
            exp_di = model_di;
        end else if (kind == 0 && unm) begin
            exp_di = 8'hFF;
        end else if (ack_at >= 1 && ack_at <= 16) begin
            exp_rq = ack_at;
            if (!is_wr) exp_di = rd_val;
        end else begin
            exp_rq = 16;
            tmo    = 1'b1;
            exp_di = 8'hFF;
        end

        @(negedge clk);
        a       = addr;
        cpu_do  = wd;
        int_vec = vec;
        mreq_n  = (kind != 0);
        iorq_n  = (kind == 0);
        m1_n    = (kind != 2);
        rd_n    = (kind == 2) ? 1'b1 : (dir == 1);
        wr_n    = (kind == 2) ? 1'b1 : (dir == 0);
        waits   = 0;
        rq      = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (wait_n) break;
            mem_ack = 1'b0;
            if (mem_req) begin
                rq++;
                if (rq == 1) begin
                    chk("mem_we", mem_we, is_wr);
                    chk("mem_addr", mem_addr, addr);
                    chk("mem_wdata", mem_wdata, wd);
                end
                if (rq == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_val;
                end
            end
            @(negedge clk);
            waits++;
        end
        mem_ack = 1'b0;
        chk("wait_cycles", waits, 1 + exp_rq);
        chk("req_cycles", rq, exp_rq);
        chk("cpu_di", cpu_di, exp_di);
        chk("bus_err", bus_err, tmo);
        chk("mem_req_done", mem_req, 0);
        model_di = exp_di;
        idle_strobes();
        @(negedge clk);
        #1;
        chk("idle_wait_n", wait_n, 1);
        chk("idle_bus_err", bus_err, 0);
        chk("idle_cpu_di", cpu_di, model_di);
    endtask

    initial begin
        int rq;
        reset     = 1'b1;
        a         = 16'h0000;
        cpu_do    = 8'h00;
        int_vec   = 8'h00;
        mem_rdata = 8'h00;
        mem_ack   = 1'b0;
        idle_strobes();
        model_di  = 8'hFF;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wait_n", wait_n, 1);
        chk("rst_cpu_di", cpu_di, 8'hFF);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_bus_err", bus_err, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed scenarios
        access(0, 0, 16'hC000, 8'h00, 3, 8'h5A, 8'h00);   // RAM read, 4 wait cycles
        access(0, 1, 16'hC123, 8'h77, 2, 8'h00, 8'h00);   // RAM write
        access(0, 1, 16'h2000, 8'h11, 1, 8'h00, 8'h00);   // ROM write dropped
        access(0, 0, 16'hFEB0, 8'h00, 1, 8'h00, 8'h00);   // unmapped read
        access(2, 0, 16'h0038, 8'h00, 1, 8'h00, 8'h48);   // int-ack
        access(0, 0, 16'hD000, 8'h00, 0, 8'h99, 8'h00);   // timeout

        // Late ack after timeout must not start anything
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("late_ack_req", mem_req, 0);
        chk("late_ack_di", cpu_di, 8'hFF);
        chk("late_ack_err", bus_err, 0);

        access(0, 0, 16'hD100, 8'h00, 16, 8'hA7, 8'h00);  // ack + timeout same cycle
        access(0, 1, 16'h7FFF, 8'h22, 1, 8'h00, 8'h00);   // top of ROM, dropped
        access(0, 1, 16'h8000, 8'h33, 2, 8'h00, 8'h00);   // first RAM, goes out
        access(0, 0, 16'hFE9F, 8'h00, 1, 8'hC1, 8'h00);   // just below unmapped
        access(0, 0, 16'hFEA0, 8'h00, 1, 8'h00, 8'h00);   // unmap low edge
        access(0, 1, 16'hFEFF, 8'h44, 1, 8'h00, 8'h00);   // unmap high edge write
        access(0, 0, 16'hFF00, 8'h00, 2, 8'hD2, 8'h00);   // just above unmapped
        access(1, 0, 16'h00FE, 8'h00, 2, 8'h6E, 8'h00);   // IO read
        access(0, 0, 16'h0100, 8'h00, 1, 8'h31, 8'h00);   // ROM read goes out
        access(0, 2, 16'hC200, 8'h55, 2, 8'hEE, 8'h00);   // rd+wr low: write

        // Strobes dropped mid-handshake: mem_req held until ack
        @(negedge clk);
        a = 16'hC010; mreq_n = 1'b0; rd_n = 1'b0;
        rq = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            mem_ack = 1'b0;
            if (!mem_req && rq > 0) break;
            if (mem_req) rq++;
            if (rq == 2) idle_strobes();
            if (rq == 5) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'h3C;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("abort_req_cycles", rq, 5);
        chk("abort_cpu_di", cpu_di, 8'h3C);
        chk("abort_wait_n", wait_n, 1);
        model_di = 8'h3C;
        access(0, 0, 16'hC020, 8'h00, 1, 8'h81, 8'h00);

        // Reset while in REQ
        @(negedge clk);
        a = 16'hC300; cpu_do = 8'h9A; mreq_n = 1'b0; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_req", mem_req, 1);
        reset = 1'b1;
        idle_strobes();
        @(negedge clk);
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_di", cpu_di, 8'hFF);
        chk("mid_rst_err", bus_err, 0);
        chk("mid_rst_wait", wait_n, 1);
        reset = 1'b0;
        model_di = 8'hFF;
        access(0, 0, 16'hC400, 8'h00, 2, 8'h17, 8'h00);

        // Randomized accesses
        for (int n = 0; n < 30; n++) begin
            int          kind, dir, ack_at, pick;
            logic [15:0] addr;
            kind = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
            dir  = ($urandom_range(0, 5) == 0) ? 2 : int'($urandom_range(0, 1));
            pick = $urandom_range(0, 3);
            case (pick)
                0: addr = 16'($urandom_range(0, 16'h7FFF));
                1: addr = 16'($urandom_range(16'hFEA0, 16'hFEFF));
                default: addr = 16'($urandom_range(16'h8000, 16'hFFFF));
            endcase
            case ($urandom_range(0, 9))
                0: ack_at = 0;
                1: ack_at = 16;
                default: ack_at = $urandom_range(1, 6);
            endcase
            access(kind, dir, addr, 8'($urandom), ack_at, 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
